latch_sampler: RTL and testbench
================================

LATCH_SAMPLER -- requirements
Module: latch_sampler

Interface
REQ-001 Parameter WIDTH, default 1; data width of the sampled latch output.
REQ-002 Parameter STABLE_CYCLES, default 4, legal range 1..255; number of consecutive qualifying cycles required before a value is accepted.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in  input  WIDTH  data driven by an upstream transparent latch.
REQ-006 enable  input  1  upstream latch enable; high means the latch is transparent and the data is untrusted.
REQ-007 out  output  WIDTH  accepted stable value, registered.
REQ-008 out_valid  output  1  out holds an undelivered value.
REQ-009 out_ready  input  1  consumer accepts out in a cycle where out_valid=1.
REQ-010 overrun  output  1  sticky flag: a new stable value was seen while a delivery was pending.
REQ-011 overrun_clr  input  1  clears overrun.

Function
REQ-012 The block SHALL hold a candidate register cand (WIDTH) and a counter cnt that saturates at STABLE_CYCLES.
REQ-013 Each edge with enable=1: cand<=in, cnt<=0.
REQ-014 Each edge with enable=0 and in!=cand: cand<=in, cnt<=1.
REQ-015 Each edge with enable=0 and in==cand: cnt<=min(cnt+1, STABLE_CYCLES).
REQ-016 cand is "stable" in any cycle where cnt==STABLE_CYCLES.
REQ-017 The block SHALL implement states SETTLE (out_valid=0) and HOLD (out_valid=1).
REQ-018 SETTLE->HOLD when cand is stable and either no value has been delivered since reset or cand!=last; on that edge out<=cand, last<=cand, out_valid<=1.
REQ-019 A stable cand equal to last SHALL NOT be redelivered; the block stays in SETTLE.
REQ-020 HOLD->SETTLE on an edge with out_valid=1 and out_ready=1; out SHALL retain its value after the handshake.
REQ-021 In HOLD, out and out_valid SHALL NOT change until the handshake, regardless of in or enable.
REQ-022 In HOLD, an edge where cand is stable and cand!=last SHALL set overrun<=1; the pending value is kept and the newer value is delivered after the handshake if it is still stable.
REQ-023 On an edge with a handshake and a qualifying stable cand!=last in the same cycle, the handshake completes; delivery of the new value occurs on the next edge, not the same one.
REQ-024 overrun_clr=1 clears overrun; if a set condition coincides with it on the same edge, set wins.
REQ-025 Latency: a value presented with enable=0 from edge t onward SHALL raise out_valid after edge t+STABLE_CYCLES, provided the block is in SETTLE.
REQ-026 Any change of in, or enable=1, before cnt saturates SHALL restart qualification; no partial value is ever delivered.

Reset
REQ-027 On an edge with rst=1: out=0, out_valid=0, overrun=0, cand=0, cnt=0, state=SETTLE, last marked invalid.
REQ-028 rst SHALL override all other inputs, including during HOLD with a pending delivery; the pending value is discarded.

Verification
REQ-029 STABLE_CYCLES=4, WIDTH=8, enable=0, in=0x5A from edge 0, out_ready=0 -> out_valid rises after edge 4, out=0x5A.
REQ-030 Same setup, but in toggles 0x5A/0x5B every 2 cycles for 10 cycles, then holds 0x5B -> out_valid stays low until 4 edges after the last change, then out=0x5B.
REQ-031 Deliver 0x11, handshake, keep in=0x11 for 20 cycles -> no second out_valid pulse.
REQ-032 Deliver 0x11 and hold out_ready=0; in=0x22 stable for 6 cycles -> overrun=1 and out stays 0x11; then out_ready=1 for one cycle -> out=0x22 with out_valid=1 on the next edge.
REQ-033 enable=1 while in=0x33 for 10 cycles, then enable=0 -> out_valid rises exactly 4 edges after enable falls.
REQ-034 Assert rst during HOLD with overrun=1 -> next cycle out=0, out_valid=0, overrun=0; the same value presented again is delivered, since last is invalid.

Source files
------------

// File: rtl/latch_sampler.sv
// latch_sampler: qualifies data from an upstream transparent latch. A value
// is accepted only after it has stayed unchanged, with the latch closed, for
// STABLE_CYCLES consecutive edges. Each accepted value is delivered once
// through a valid/ready handshake. A new value that qualifies while a
// delivery is still pending raises a sticky overrun flag.
module latch_sampler #(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             enable,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  localparam int CW = 8;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] cand_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] last_reg;
  logic             last_valid_reg;

  logic stable;
  logic is_new;
  logic deliver;
  logic overrun_set;

  // The candidate has been seen unchanged for enough closed-latch edges.
  assign stable      = (cnt_reg == CNT_MAX);
  // The candidate differs from the most recent delivery (or none exists yet).
  assign is_new      = !last_valid_reg || (cand_reg != last_reg);
  assign deliver     = (state_reg == SETTLE) && stable && is_new;
  assign overrun_set = (state_reg == HOLD) && stable && (cand_reg != last_reg);

  // Track the candidate value and how long it has been stable behind a closed latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else if (enable) begin
      cand_reg <= in;
      cnt_reg  <= '0;
    end else if (in != cand_reg) begin
      cand_reg <= in;
      cnt_reg  <= CW'(1);
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg  <= cnt_reg + CW'(1);
    end
  end

  // Delivery FSM: register an accepted value, hold it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SETTLE;
      out            <= '0;
      out_valid      <= 1'b0;
      last_reg       <= '0;
      last_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        SETTLE: begin
          if (deliver) begin
            out            <= cand_reg;
            last_reg       <= cand_reg;
            last_valid_reg <= 1'b1;
            out_valid      <= 1'b1;
            state_reg      <= HOLD;
          end
        end
        HOLD: begin
          // A newer qualifying value waits until after the handshake edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= SETTLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_reg <= SETTLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a coincident set takes priority over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (overrun_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_latch_sampler.sv
// tb_latch_sampler: directed scenarios plus a randomized run, all checked
// against a history-based reference model of the sampler.
module tb_latch_sampler;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         en = 1'b0;
  logic [W-1:0] out;
  logic         out_valid;
  logic         rdy = 1'b0;
  logic         overrun;
  logic         clr = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model: queue of the last S (enable, in) samples since reset.
  logic [W:0]   hist[$];
  logic         m_valid;
  logic [W-1:0] m_out;
  logic [W-1:0] m_last;
  logic         m_last_ok;
  logic         m_ovr;

  latch_sampler #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .enable     (en),
    .out        (out),
    .out_valid  (out_valid),
    .out_ready  (rdy),
    .overrun    (overrun),
    .overrun_clr(clr)
  );

  always #5 clk = ~clk;

  // Stable means the last S sampled edges all had the latch closed and the same data.
  function automatic bit m_stable();
    if (hist.size() < S) return 1'b0;
    for (int i = 0; i < S; i++) begin
      if (hist[i][W] || hist[i][W-1:0] != hist[S-1][W-1:0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit           st;
    bit           set;
    logic [W-1:0] c;
    if (rst) begin
      hist.delete();
      m_valid = 0; m_out = '0; m_last = '0; m_last_ok = 0; m_ovr = 0;
      return;
    end
    st  = m_stable();
    c   = (hist.size() > 0) ? hist[hist.size()-1][W-1:0] : '0;
    set = 0;
    if (!m_valid) begin
      if (st && (!m_last_ok || c != m_last)) begin
        m_valid = 1; m_out = c; m_last = c; m_last_ok = 1;
      end
    end else begin
      if (st && c != m_last) set = 1;
      if (rdy) m_valid = 0;
    end
    if (set) m_ovr = 1;
    else if (clr) m_ovr = 0;
    hist.push_back({en, din});
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; rdy = 0; clr = 0; din = '0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({out, out_valid, overrun} !== {8'h00, 1'b0, 1'b0}) begin
      $display("FAIL reset: out=%h valid=%b ovr=%b, expected 00 0 0", out, out_valid, overrun);
    end else pass_cnt++;
    $display("reset: out=%h valid=%b ovr=%b", out, out_valid, overrun);
  endtask

  task automatic test_latency();
    do_reset();
    din = 8'h5A;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== (i >= 4) || (i >= 4 && out !== 8'h5A)) begin
        $display("FAIL latency edge%0d: valid=%b out=%h, expected valid=%b out=5a", i, out_valid, out, (i >= 4));
      end else pass_cnt++;
    end
    $display("latency: out=%h valid=%b", out, out_valid);
  endtask

  task automatic test_toggle();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      din = (i < 10 && ((i / 2) % 2 == 0)) ? 8'h5A : 8'h5B;
      tick();
      total_cnt++;
      if ({out, out_valid, overrun} !== {m_out, m_valid, m_ovr}) begin
        $display("FAIL toggle cyc%0d: out=%h valid=%b ovr=%b, expected %h %b %b", i, out, out_valid, overrun, m_out, m_valid, m_ovr);
      end else pass_cnt++;
    end
    total_cnt++;
    if (out_valid !== 1'b1 || out !== 8'h5B) begin
      $display("FAIL toggle_final: valid=%b out=%h, expected 1 5b", out_valid, out);
    end else pass_cnt++;
    $display("toggle: out=%h valid=%b", out, out_valid);
  endtask

  task automatic test_no_redeliver();
    int pulses;
    do_reset();
    din = 8'h11;
    for (int i = 0; i < 5; i++) tick();
    rdy = 1;
    tick();
    rdy = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) pulses++;
      total_cnt++;
      if ({out, out_valid, overrun} !== {m_out, m_valid, m_ovr}) begin
        $display("FAIL no_redeliver cyc%0d: out=%h valid=%b ovr=%b, expected %h %b %b", i, out, out_valid, overrun, m_out, m_valid, m_ovr);
      end else pass_cnt++;
    end
    total_cnt++;
    if (pulses != 0) begin
      $display("FAIL no_redeliver_pulses: got %0d, expected 0", pulses);
    end else pass_cnt++;
    $display("no_redeliver: out=%h pulses=%0d", out, pulses);
  endtask

  task automatic test_overrun();
    do_reset();
    din = 8'h11;
    for (int i = 0; i < 5; i++) tick();
    din = 8'h22;
    for (int i = 0; i < 6; i++) tick();
    total_cnt++;
    if ({out, out_valid, overrun} !== {8'h11, 1'b1, 1'b1}) begin
      $display("FAIL overrun_hold: out=%h valid=%b ovr=%b, expected 11 1 1", out, out_valid, overrun);
    end else pass_cnt++;
    rdy = 1;
    tick();
    rdy = 0;
    total_cnt++;
    if (out_valid !== 1'b0) begin
      $display("FAIL overrun_handshake: valid=%b, expected 0", out_valid);
    end else pass_cnt++;
    tick();
    total_cnt++;
    if ({out, out_valid} !== {8'h22, 1'b1}) begin
      $display("FAIL overrun_redeliver: out=%h valid=%b, expected 22 1", out, out_valid);
    end else pass_cnt++;
    clr = 1;
    tick();
    total_cnt++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_clear: ovr=%b, expected 0", overrun);
    end else pass_cnt++;
    din = 8'h33;
    for (int i = 0; i < 6; i++) tick();
    clr = 0;
    total_cnt++;
    if ({out, overrun} !== {8'h22, 1'b1}) begin
      $display("FAIL overrun_set_wins: out=%h ovr=%b, expected 22 1", out, overrun);
    end else pass_cnt++;
    $display("overrun: out=%h valid=%b ovr=%b", out, out_valid, overrun);
  endtask

  task automatic test_enable();
    do_reset();
    din = 8'h33;
    en = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b0) begin
        $display("FAIL enable_open cyc%0d: valid=%b, expected 0", i, out_valid);
      end else pass_cnt++;
    end
    en = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== (i >= 4) || (i >= 4 && out !== 8'h33)) begin
        $display("FAIL enable_release edge%0d: valid=%b out=%h, expected valid=%b out=33", i, out_valid, out, (i >= 4));
      end else pass_cnt++;
    end
    $display("enable: out=%h valid=%b", out, out_valid);
  endtask

  task automatic test_reset_hold();
    do_reset();
    din = 8'h44;
    for (int i = 0; i < 5; i++) tick();
    din = 8'h55;
    for (int i = 0; i < 6; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    total_cnt++;
    if ({out, out_valid, overrun} !== {8'h00, 1'b0, 1'b0}) begin
      $display("FAIL reset_hold: out=%h valid=%b ovr=%b, expected 00 0 0", out, out_valid, overrun);
    end else pass_cnt++;
    din = 8'h44;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if ({out, out_valid} !== {8'h44, 1'b1}) begin
      $display("FAIL reset_redeliver: out=%h valid=%b, expected 44 1", out, out_valid);
    end else pass_cnt++;
    $display("reset_hold: out=%h valid=%b", out, out_valid);
  endtask

  task automatic test_random();
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 15) din = W'($urandom_range(3));
      en  = ($urandom_range(99) < 8);
      rdy = ($urandom_range(99) < 25);
      clr = ($urandom_range(99) < 10);
      rst = ($urandom_range(999) < 5);
      tick();
      total_cnt++;
      if ({out, out_valid, overrun} !== {m_out, m_valid, m_ovr}) begin
        errs++;
        $display("FAIL random cyc%0d: out=%h valid=%b ovr=%b, expected %h %b %b", i, out, out_valid, overrun, m_out, m_valid, m_ovr);
      end else pass_cnt++;
    end
    rst = 0; en = 0; rdy = 0; clr = 0;
    $display("random: 3000 cycles, %0d errors", errs);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_toggle();
    test_no_redeliver();
    test_overrun();
    test_enable();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
